retrosoc_pinmux: RTL and testbench
==================================

// Module: retrosoc_pinmux
// PURPOSE
//  Runtime-configurable pad multiplexer; successor to the fixed pin map in the TT top level.
//  Each of NUM_PADS bidirectional pads is routed to one of NUM_FUNC peripheral functions, selected by registers.
//  Pads get registered outputs and synchronised inputs. Changing a select inserts an output-disable guard window.
//  A sticky lock freezes the mapping. Sits between retrosoc_tiny peripheral pins and the uo/uio pad ring.
// PARAMETERS
//  NUM_PADS     8        number of muxed pads (1..32)
//  NUM_FUNC     4        functions per pad (2..16); SEL_W = $clog2(NUM_FUNC)
//  GUARD_CYC    2        cycles pad_oe_o is forced 0 after a select change (1..255)
//  SYNC_STAGES  2        input synchroniser depth (>=2)
//  IN_IDLE      {NUM_PADS{1'b0}}  per-pad value driven to unselected/guarded function inputs (1 for I2C)
// PORTS
//  clk_i        in   1                  system clock
//  rst_n_i      in   1                  asynchronous active-low reset
//  cfg_valid_i  in   1                  config request valid
//  cfg_ready_o  out  1                  config request ready (constant 1 out of reset)
//  cfg_we_i     in   1                  1 = write, 0 = read
//  cfg_addr_i   in   8                  0..NUM_PADS-1 = pad select; NUM_PADS = lock register
//  cfg_wdata_i  in   8                  write data
//  cfg_rvalid_o out  1                  response strobe, one cycle after accept
//  cfg_rdata_o  out  8                  read data (0 on writes/errors)
//  cfg_err_o    out  1                  response error, valid with cfg_rvalid_o
//  fn_out_i     in   NUM_PADS*NUM_FUNC  function output data, index p*NUM_FUNC+f
//  fn_oe_i      in   NUM_PADS*NUM_FUNC  function output enable, active high
//  fn_in_o      out  NUM_PADS*NUM_FUNC  synchronised pad input to each function
//  pad_in_i     in   NUM_PADS           pad input path (uio_in/ui_in)
//  pad_out_o    out  NUM_PADS           pad output data
//  pad_oe_o     out  NUM_PADS           pad output enable, active high
// BEHAVIOUR
//  Reset: sel[p]=0, lock=0, all pads ACTIVE. pad_out_o=0, pad_oe_o=0, cfg_rvalid_o=0, cfg_rdata_o=0,
//   cfg_err_o=0. Sync flops reset to IN_IDLE[p]. cfg_ready_o=0 in reset, 1 afterwards.
//  Output path: pad_out_o[p]/pad_oe_o[p] <= fn_out_i/fn_oe_i[p*NUM_FUNC+sel[p]]. Latency 1 cycle. In GUARD, oe<=0.
//  Input path: SYNC_STAGES flop chain per pad. fn_in_o[p*NUM_FUNC+sel[p]] = sync output.
//   Other functions of pad p get IN_IDLE[p]. In GUARD, all functions of p get IN_IDLE[p].
//  Per-pad FSM: ACTIVE --(accepted write, new sel != sel, not locked)--> GUARD, cnt=GUARD_CYC, sel<=new.
//   GUARD: cnt decrements each cycle. At cnt==1, next state is ACTIVE. A new differing write in GUARD reloads cnt and sel.
//  Write handling:
//   - Select data is wdata[SEL_W-1:0]. Value >= NUM_FUNC: ignored, err=1.
//   - Write equal to the current sel: no guard, err=0.
//   - Lock register: wdata[0]=1 sets lock (sticky until rst_n_i). Writing 0 is ignored, err=0.
//   - Select write while locked: ignored, err=1.
//  Read data:
//   - pad select: rdata = {guard_active, 7-SEL_W zeros, sel}.
//   - lock register: rdata = {7'b0, lock}.
//  Address > NUM_PADS: err=1, rdata=0, no state change.
//  Response: cfg_rvalid_o pulses one cycle after each accept (valid&ready). Back-to-back requests are accepted every cycle.
//  Reset mid-guard aborts GUARD immediately: sel=0, oe=0.
// TESTING
//  T1 reset, fn_oe_i all 1, fn_out_i[f0]=1 -> 1 cycle later pad_out_o=8'hFF, pad_oe_o=8'hFF; all sel read 0.
//  T2 write addr2=3, GUARD_CYC=2 -> pad_oe_o[2]=0 for 2 cycles, then follows fn_oe_i[11]; read addr2 mid-guard = 8'h83.
//  T3 pad_in_i[5] 0->1, sel[5]=1 -> fn_in_o[21] rises after SYNC_STAGES cycles; fn_in_o[20,22,23] stay IN_IDLE[5].
//  T4 write lock=1, then addr0=2 -> err=1, sel[0] unchanged, pad 0 stays ACTIVE; read addr NUM_PADS = 8'h01.
//  T5 addr=NUM_PADS+1 and sel=NUM_FUNC writes -> err=1, no state change; rewrite of current sel -> err=0, no guard.
//  T6 assert rst_n_i mid-guard -> outputs 0 asynchronously; after release sel=0, lock=0, cfg_ready_o=1.

Source files
------------

// File: rtl/retrosoc_pinmux.sv
// retrosoc_pinmux
//   Runtime-configurable pad multiplexer. Each of NUM_PADS bidirectional pads
//   is routed to one of NUM_FUNC peripheral functions chosen by a per-pad
//   select register. Pad outputs are registered and pad inputs synchronised.
//   Changing a select opens an output-disable guard window of GUARD_CYC cycles.
//   A sticky lock register freezes the mapping until reset.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   cfg_valid_i/ready_o config request handshake (ready is 1 once out of reset)
//   cfg_we_i            1 = write, 0 = read
//   cfg_addr_i          0..NUM_PADS-1 pad select, NUM_PADS lock register
//   cfg_wdata_i         write data
//   cfg_rvalid_o        response strobe, one cycle after accept
//   cfg_rdata_o         read data (0 on writes and errors)
//   cfg_err_o           response error, valid with cfg_rvalid_o
//   fn_out_i, fn_oe_i   per-function output data / enable, index p*NUM_FUNC+f
//   fn_in_o             synchronised pad input presented to each function
//   pad_in_i            pad input path
//   pad_out_o, pad_oe_o pad output data / enable
module retrosoc_pinmux #(
  parameter int unsigned         NUM_PADS    = 8,
  parameter int unsigned         NUM_FUNC    = 4,
  parameter int unsigned         GUARD_CYC   = 2,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_PADS-1:0] IN_IDLE     = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic                         cfg_we_i,
  input  logic [7:0]                   cfg_addr_i,
  input  logic [7:0]                   cfg_wdata_i,
  output logic                         cfg_rvalid_o,
  output logic [7:0]                   cfg_rdata_o,
  output logic                         cfg_err_o,
  input  logic [NUM_PADS*NUM_FUNC-1:0] fn_out_i,
  input  logic [NUM_PADS*NUM_FUNC-1:0] fn_oe_i,
  output logic [NUM_PADS*NUM_FUNC-1:0] fn_in_o,
  input  logic [NUM_PADS-1:0]          pad_in_i,
  output logic [NUM_PADS-1:0]          pad_out_o,
  output logic [NUM_PADS-1:0]          pad_oe_o
);

  localparam int unsigned SEL_W      = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;
  localparam logic [7:0]  LOCK_ADDR  = 8'(NUM_PADS);
  localparam logic [7:0]  FUNC_LIM   = 8'(NUM_FUNC);
  localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYC);

  typedef enum logic {
    PAD_ACTIVE = 1'b0,
    PAD_GUARD  = 1'b1
  } pad_state_e;

  pad_state_e             state_q [NUM_PADS];
  pad_state_e             state_d [NUM_PADS];
  logic [SEL_W-1:0]       sel_q   [NUM_PADS];
  logic [SEL_W-1:0]       sel_d   [NUM_PADS];
  logic [7:0]             cnt_q   [NUM_PADS];
  logic [7:0]             cnt_d   [NUM_PADS];
  logic [SYNC_STAGES-1:0] sync_q  [NUM_PADS];

  logic                lock_q, lock_d;
  logic                ready_q;
  logic                rvalid_q;
  logic                err_q, err_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [NUM_PADS-1:0] pad_out_q, pad_out_d;
  logic [NUM_PADS-1:0] pad_oe_q, pad_oe_d;
  logic [NUM_FUNC-1:0] fo_v, foe_v;

  logic             accept;
  logic             is_pad;
  logic             is_lock;
  logic             sel_ok;
  logic [SEL_W-1:0] wsel;

  assign accept  = cfg_valid_i & ready_q;
  assign is_pad  = (cfg_addr_i < LOCK_ADDR);
  assign is_lock = (cfg_addr_i == LOCK_ADDR);
  assign wsel    = cfg_wdata_i[SEL_W-1:0];
  // The whole write byte is range-checked, so out-of-range values are
  // rejected even when their low SEL_W bits would alias a legal select.
  assign sel_ok  = (cfg_wdata_i < FUNC_LIM);

  // Per-pad guard FSM, lock register and config response.
  always_comb begin
    lock_d  = lock_q;
    rdata_d = '0;
    err_d   = 1'b0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      state_d[p] = state_q[p];
      sel_d[p]   = sel_q[p];
      cnt_d[p]   = cnt_q[p];
      if (state_q[p] == PAD_GUARD) begin
        cnt_d[p] = cnt_q[p] - 8'd1;
        if (cnt_q[p] == 8'd1) begin
          state_d[p] = PAD_ACTIVE;
        end
      end
    end

    if (accept) begin
      if (cfg_we_i) begin
        if (is_pad) begin
          if (lock_q || !sel_ok) begin
            err_d = 1'b1;
          end else begin
            for (int unsigned p = 0; p < NUM_PADS; p++) begin
              // A differing write also restarts an already running guard.
              if (cfg_addr_i == 8'(p) && wsel != sel_q[p]) begin
                state_d[p] = PAD_GUARD;
                cnt_d[p]   = GUARD_LOAD;
                sel_d[p]   = wsel;
              end
            end
          end
        end else if (is_lock) begin
          lock_d = lock_q | cfg_wdata_i[0];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        if (is_pad) begin
          for (int unsigned p = 0; p < NUM_PADS; p++) begin
            if (cfg_addr_i == 8'(p)) begin
              rdata_d    = 8'(sel_q[p]);
              rdata_d[7] = (state_q[p] == PAD_GUARD);
            end
          end
        end else if (is_lock) begin
          rdata_d = {7'b0, lock_q};
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Pad output selection and function input fan-out.
  always_comb begin
    pad_out_d = '0;
    pad_oe_d  = '0;
    fn_in_o   = '0;
    fo_v      = '0;
    foe_v     = '0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      fo_v         = fn_out_i[p*NUM_FUNC +: NUM_FUNC];
      foe_v        = fn_oe_i[p*NUM_FUNC +: NUM_FUNC];
      pad_out_d[p] = fo_v[sel_q[p]];
      pad_oe_d[p]  = (state_q[p] == PAD_GUARD) ? 1'b0 : foe_v[sel_q[p]];
      for (int unsigned f = 0; f < NUM_FUNC; f++) begin
        fn_in_o[p*NUM_FUNC + f] =
          (state_q[p] == PAD_ACTIVE && sel_q[p] == SEL_W'(f)) ?
          sync_q[p][SYNC_STAGES-1] : IN_IDLE[p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        state_q[p] <= PAD_ACTIVE;
        sel_q[p]   <= '0;
        cnt_q[p]   <= '0;
        sync_q[p]  <= {SYNC_STAGES{IN_IDLE[p]}};
      end
      lock_q    <= 1'b0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        state_q[p] <= state_d[p];
        sel_q[p]   <= sel_d[p];
        cnt_q[p]   <= cnt_d[p];
        sync_q[p]  <= {sync_q[p][SYNC_STAGES-2:0], pad_in_i[p]};
      end
      lock_q    <= lock_d;
      ready_q   <= 1'b1;
      rvalid_q  <= accept;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
    end
  end

  assign cfg_ready_o  = ready_q;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_err_o    = err_q;
  assign pad_out_o    = pad_out_q;
  assign pad_oe_o     = pad_oe_q;

endmodule

// File: tb/tb_retrosoc_pinmux.sv
// Testbench for retrosoc_pinmux: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_retrosoc_pinmux;

  localparam int unsigned NP   = 8;
  localparam int unsigned NF   = 4;
  localparam int unsigned GC   = 2;
  localparam int unsigned SS   = 2;
  localparam logic [NP-1:0] IDLE = 8'hA0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic             cfg_we = 1'b0;
  logic [7:0]       cfg_addr = '0;
  logic [7:0]       cfg_wdata = '0;
  logic             cfg_rvalid;
  logic [7:0]       cfg_rdata;
  logic             cfg_err;
  logic [NP*NF-1:0] fn_out = '0;
  logic [NP*NF-1:0] fn_oe = '0;
  logic [NP*NF-1:0] fn_in;
  logic [NP-1:0]    pad_in = '0;
  logic [NP-1:0]    pad_out;
  logic [NP-1:0]    pad_oe;

  int n_tests = 0;
  int n_fail  = 0;

  retrosoc_pinmux #(
    .NUM_PADS   (NP),
    .NUM_FUNC   (NF),
    .GUARD_CYC  (GC),
    .SYNC_STAGES(SS),
    .IN_IDLE    (IDLE)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o (cfg_rdata),
    .cfg_err_o   (cfg_err),
    .fn_out_i    (fn_out),
    .fn_oe_i     (fn_oe),
    .fn_in_o     (fn_in),
    .pad_in_i    (pad_in),
    .pad_out_o   (pad_out),
    .pad_oe_o    (pad_oe)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_sel [NP];
  int            m_gl  [NP];   // guard cycles remaining, 0 = pad active
  bit            m_lock;
  bit            m_ready;
  logic [NP-1:0] e_out, e_oe;
  bit            e_rv, e_err;
  logic [7:0]    e_rdata;
  logic [NP-1:0] hist[$];      // pad_in samples, oldest first

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_sel[p] = 0;
      m_gl[p]  = 0;
    end
    m_lock  = 0;
    m_ready = 0;
    e_out   = '0;
    e_oe    = '0;
    e_rv    = 0;
    e_err   = 0;
    e_rdata = '0;
    hist.delete();
  endtask

  task automatic model_step();
    int a, w;
    bit acc;
    a = int'(cfg_addr);
    w = int'(cfg_wdata);
    for (int p = 0; p < NP; p++) begin
      e_out[p] = fn_out[p*NF + m_sel[p]];
      e_oe[p]  = (m_gl[p] > 0) ? 1'b0 : fn_oe[p*NF + m_sel[p]];
    end
    acc     = cfg_valid && m_ready;
    e_rv    = acc;
    e_rdata = '0;
    e_err   = 0;
    if (acc) begin
      if (!cfg_we) begin
        if (a < NP)       e_rdata = 8'((m_gl[a] > 0 ? 128 : 0) + m_sel[a]);
        else if (a == NP) e_rdata = 8'(m_lock);
        else              e_err = 1;
      end else begin
        if (a < NP) begin
          if (m_lock || w >= NF) e_err = 1;
        end else if (a > NP) e_err = 1;
      end
    end
    for (int p = 0; p < NP; p++) if (m_gl[p] > 0) m_gl[p]--;
    if (acc && cfg_we) begin
      if (a < NP && !m_lock && w < NF && w != m_sel[a]) begin
        m_sel[a] = w;
        m_gl[a]  = GC;
      end
      if (a == NP && cfg_wdata[0]) m_lock = 1;
    end
    hist.push_back(pad_in);
    if (hist.size() > SS) void'(hist.pop_front());
    m_ready = 1;
  endtask

  function automatic logic [NP*NF-1:0] exp_fn_in();
    logic [NP*NF-1:0] v;
    logic s;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      s = (hist.size() >= SS) ? hist[0][p] : IDLE[p];
      for (int f = 0; f < NF; f++)
        v[p*NF + f] = (m_gl[p] == 0 && m_sel[p] == f) ? s : IDLE[p];
    end
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("pad_out",   32'(pad_out),    32'(e_out));
      check("pad_oe",    32'(pad_oe),     32'(e_oe));
      check("fn_in",     32'(fn_in),      32'(exp_fn_in()));
      check("cfg_ready", 32'(cfg_ready),  32'(m_ready));
      check("rvalid",    32'(cfg_rvalid), 32'(e_rv));
      check("rdata",     32'(cfg_rdata),  32'(e_rdata));
      check("err",       32'(cfg_err),    32'(e_err));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    cfg_valid = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wd;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int r;
    // T1: reset state, then function 0 routed to every pad
    repeat (2) @(posedge clk);
    at_neg();
    check("rst_pad_out", 32'(pad_out),   32'h0);
    check("rst_pad_oe",  32'(pad_oe),    32'h0);
    check("rst_ready",   32'(cfg_ready), 32'h0);
    check("rst_rvalid",  32'(cfg_rvalid), 32'h0);
    tick();
    rst_n  = 1'b1;
    fn_oe  = '1;
    fn_out = 32'h1111_1111;
    tick();
    at_neg();
    check("t1_pad_out", 32'(pad_out),   32'hFF);
    check("t1_pad_oe",  32'(pad_oe),    32'hFF);
    check("t1_ready",   32'(cfg_ready), 32'h1);
    for (int p = 0; p < NP; p++) begin
      do_req(1'b0, 8'(p), 8'h00);
      at_neg();
      check("t1_sel_read", 32'(cfg_rdata), 32'h0);
    end

    // T2: select change opens the guard window
    do_req(1'b1, 8'd2, 8'd3);
    do_req(1'b0, 8'd2, 8'd0);
    at_neg();
    check("t2_read_guard", 32'(cfg_rdata), 32'h83);
    check("t2_oe_g1",      32'(pad_oe[2]), 32'h0);
    check("t2_model_sel",  32'(m_sel[2]),  32'h3);
    tick();
    at_neg();
    check("t2_oe_g2", 32'(pad_oe[2]), 32'h0);
    tick();
    at_neg();
    check("t2_oe_act", 32'(pad_oe[2]), 32'h1);
    fn_oe[11] = 1'b0;
    tick();
    at_neg();
    check("t2_oe_follow", 32'(pad_oe[2]), 32'h0);
    fn_oe[11] = 1'b1;

    // T3: input synchroniser latency and idle fan-out
    do_req(1'b1, 8'd5, 8'd1);
    repeat (3) tick();
    at_neg();
    check("t3_in_low",  32'(fn_in[21]), 32'h0);
    check("t3_idle_20", 32'(fn_in[20]), 32'h1);
    pad_in[5] = 1'b1;
    tick();
    at_neg();
    check("t3_in_stage1", 32'(fn_in[21]), 32'h0);
    tick();
    at_neg();
    check("t3_in_high", 32'(fn_in[21]), 32'h1);
    check("t3_idle_20b", 32'(fn_in[20]), 32'h1);
    check("t3_idle_22", 32'(fn_in[22]), 32'h1);
    check("t3_idle_23", 32'(fn_in[23]), 32'h1);
    pad_in[5] = 1'b0;

    // T5: error cases and same-value rewrite
    do_req(1'b1, 8'(NP + 1), 8'd0);
    at_neg();
    check("t5_bad_addr_err", 32'(cfg_err), 32'h1);
    do_req(1'b1, 8'd3, 8'(NF));
    at_neg();
    check("t5_bad_sel_err", 32'(cfg_err), 32'h1);
    do_req(1'b0, 8'd3, 8'd0);
    at_neg();
    check("t5_sel3_kept", 32'(cfg_rdata), 32'h0);
    do_req(1'b1, 8'd2, 8'd3);
    at_neg();
    check("t5_same_err", 32'(cfg_err),   32'h0);
    check("t5_same_oe",  32'(pad_oe[2]), 32'h1);
    tick();
    at_neg();
    check("t5_same_oe2", 32'(pad_oe[2]), 32'h1);
    do_req(1'b0, 8'd2, 8'd0);
    at_neg();
    check("t5_same_read", 32'(cfg_rdata), 32'h03);

    // T6: reset in the middle of a guard window
    do_req(1'b1, 8'd1, 8'd2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_oe",     32'(pad_oe),     32'h0);
    check("t6_async_out",    32'(pad_out),    32'h0);
    check("t6_async_rvalid", 32'(cfg_rvalid), 32'h0);
    check("t6_async_ready",  32'(cfg_ready),  32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    at_neg();
    check("t6_ready", 32'(cfg_ready), 32'h1);
    do_req(1'b0, 8'd1, 8'd0);
    at_neg();
    check("t6_sel1", 32'(cfg_rdata), 32'h0);
    do_req(1'b0, 8'(NP), 8'd0);
    at_neg();
    check("t6_lock", 32'(cfg_rdata), 32'h0);

    // T4: lock freezes selects
    do_req(1'b1, 8'(NP), 8'd1);
    at_neg();
    check("t4_lock_err", 32'(cfg_err), 32'h0);
    do_req(1'b1, 8'd0, 8'd2);
    at_neg();
    check("t4_locked_err", 32'(cfg_err), 32'h1);
    do_req(1'b0, 8'd0, 8'd0);
    at_neg();
    check("t4_sel0", 32'(cfg_rdata), 32'h0);
    do_req(1'b1, 8'(NP), 8'd0);
    do_req(1'b0, 8'(NP), 8'd0);
    at_neg();
    check("t4_lock_read", 32'(cfg_rdata), 32'h01);
    check("t4_lock_rerr", 32'(cfg_err),   32'h0);

    // Random phase, starting unlocked
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      fn_out    = $urandom;
      fn_oe     = $urandom;
      pad_in    = 8'($urandom);
      cfg_valid = ($urandom_range(0, 1) == 1);
      cfg_we    = ($urandom_range(0, 1) == 1);
      r         = int'($urandom_range(0, 15));
      cfg_addr  = (r == 15) ? 8'($urandom) : 8'($urandom_range(0, NP + 1));
      cfg_wdata = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, NF));
      if (cfg_addr == 8'(NP) && cfg_we && $urandom_range(0, 29) != 0)
        cfg_wdata[0] = 1'b0;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #4 rst_n = 1'b1;
      end
    end
    cfg_valid = 1'b0;
    tick();
    at_neg();
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
